// File: rtl/nn_load_sequencer.sv
// Avalon-MM load sequencer: streams host writes into the CNN image/weight/bias RAMs, then starts compute.
// Optional running payload checksum at address 2 when NN_LOAD_CHECKSUM_EN is defined.
module nn_load_sequencer #(
    parameter int unsigned IMG_WORDS    = 196,
    parameter int unsigned CONV_BYTES   = 55744,
    parameter int unsigned DENSE_BYTES  = 37578,
    parameter int unsigned DENSEB_BYTES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        chipselect,
    input  logic        write,
    input  logic        read,
    input  logic [1:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        img_wren,
    output logic [31:0] img_data,
    output logic [9:0]  img_addr,
    output logic        conv_wren,
    output logic [15:0] conv_addr,
    output logic        dense_wren,
    output logic [15:0] dense_addr,
    output logic        denseb_wren,
    output logic [7:0]  denseb_addr,
    output logic [7:0]  wt_data,
    output logic        compute_start,
    input  logic        compute_done
);
    localparam int unsigned CW = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LD_IMG    = 3'd1,
        LD_CONV   = 3'd2,
        LD_DENSE  = 3'd3,
        LD_DENSEB = 3'd4,
        RUN       = 3'd5,
        DONE      = 3'd6
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic          error;
    logic [31:0]   checksum;
    logic          wr, rd, abort, start_ok, data_wr, loading, busy, last;
    logic [CW-1:0] phase_last;
    logic [31:0]   rd_mux;

    assign wr       = chipselect & write;
    assign rd       = chipselect & read;
    assign abort    = wr && (address == 2'd0) && writedata[1];
    assign start_ok = wr && (address == 2'd0) && writedata[0] && !writedata[1]
                      && (state == IDLE || state == DONE);
    assign data_wr  = wr && (address == 2'd1);
    assign loading  = (state == LD_IMG) || (state == LD_CONV) || (state == LD_DENSE) || (state == LD_DENSEB);
    assign busy     = (state != IDLE) && (state != DONE);
    assign last     = (count == phase_last);

    // Final count value of the current load phase
    always_comb begin
        phase_last = '0;
        case (state)
            LD_IMG:    phase_last = CW'(IMG_WORDS - 1);
            LD_CONV:   phase_last = CW'(CONV_BYTES - 1);
            LD_DENSE:  phase_last = CW'(DENSE_BYTES - 1);
            LD_DENSEB: phase_last = CW'(DENSEB_BYTES - 1);
            default:   phase_last = '0;
        endcase
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0:    rd_mux = {24'b0, error, (state == DONE), busy, 2'b0, 3'(state)};
            2'd1:    rd_mux = {16'b0, count};
            2'd2:    rd_mux = checksum;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            count         <= '0;
            error         <= 1'b0;
            readdata      <= '0;
            img_wren      <= 1'b0;
            img_data      <= '0;
            img_addr      <= '0;
            conv_wren     <= 1'b0;
            conv_addr     <= '0;
            dense_wren    <= 1'b0;
            dense_addr    <= '0;
            denseb_wren   <= 1'b0;
            denseb_addr   <= '0;
            wt_data       <= '0;
            compute_start <= 1'b0;
        end else begin
            img_wren      <= 1'b0;
            conv_wren     <= 1'b0;
            dense_wren    <= 1'b0;
            denseb_wren   <= 1'b0;
            compute_start <= 1'b0;
            if (rd) readdata <= rd_mux;

            if (abort) begin
                state <= IDLE;
                count <= '0;
            end else begin
                if (state == RUN && compute_done) state <= DONE;
                if (start_ok) begin
                    state <= LD_IMG;
                    count <= '0;
                    error <= 1'b0;
                end
                if (data_wr && !loading) error <= 1'b1;
                // One RAM write per accepted strobe, addressed by the pre-increment count
                if (data_wr && loading) begin
                    case (state)
                        LD_IMG: begin
                            img_wren <= 1'b1;
                            img_addr <= 10'(count);
                            img_data <= writedata;
                        end
                        LD_CONV: begin
                            conv_wren <= 1'b1;
                            conv_addr <= count;
                            wt_data   <= writedata[7:0];
                        end
                        LD_DENSE: begin
                            dense_wren <= 1'b1;
                            dense_addr <= count;
                            wt_data    <= writedata[7:0];
                        end
                        default: begin
                            denseb_wren <= 1'b1;
                            denseb_addr <= 8'(count);
                            wt_data     <= writedata[7:0];
                        end
                    endcase
                    if (last) begin
                        count <= '0;
                        case (state)
                            LD_IMG:   state <= LD_CONV;
                            LD_CONV:  state <= LD_DENSE;
                            LD_DENSE: state <= LD_DENSEB;
                            default: begin
                                state         <= RUN;
                                compute_start <= 1'b1;
                            end
                        endcase
                    end else begin
                        count <= count + CW'(1);
                    end
                end
            end
        end
    end

`ifdef NN_LOAD_CHECKSUM_EN
    logic [31:0] byte_sum;

    // Image words contribute all four bank bytes, weight writes only the low byte
    always_comb begin
        byte_sum = 32'(writedata[7:0]);
        if (state == LD_IMG)
            byte_sum = 32'(writedata[31:24]) + 32'(writedata[23:16])
                     + 32'(writedata[15:8])  + 32'(writedata[7:0]);
    end

    always_ff @(posedge clk) begin
        if (reset)                   checksum <= '0;
        else if (start_ok)           checksum <= '0;
        else if (data_wr && loading) checksum <= checksum + byte_sum;
    end
`else
    assign checksum = '0;
`endif

endmodule

// File: doc/nn_load_sequencer.md
Name: nn_load_sequencer

Overview:
- Avalon-MM slave controller that sequences host (HPS) loading of the CNN accelerator's on-chip RAMs, then hands control to the compute engine.
- Loading order is fixed: image words to the four image banks, conv weights, dense weights, dense biases.
- Each bus write strobe produces exactly one RAM write with an auto-incremented address. Idle bus cycles never advance the counters.
- Exposes control and status registers and a start/done handshake with the compute engine.

Parameters:
- IMG_WORDS, 196, 32-bit words to image banks (one byte per bank)
- CONV_BYTES, 55744, bytes to conv weight RAM
- DENSE_BYTES, 37578, bytes to dense weight RAM
- DENSEB_BYTES, 10, bytes to dense bias RAM

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- chipselect  in  1  Avalon slave select
- write  in  1  Avalon write strobe
- read  in  1  Avalon read strobe
- address  in  2  register select: 0 = CTRL/STATUS, 1 = DATA/COUNT, 2 = CHECKSUM
- writedata  in  32  Avalon write data
- readdata  out  32  Avalon read data, registered
- img_wren  out  1  write enable shared by image banks 0-3
- img_data  out  32  [31:24]→bank0, [23:16]→bank1, [15:8]→bank2, [7:0]→bank3
- img_addr  out  10  image bank address
- conv_wren  out  1  conv RAM write enable
- conv_addr  out  16  conv RAM address
- dense_wren  out  1  dense RAM write enable
- dense_addr  out  16  dense RAM address
- denseb_wren  out  1  dense bias RAM write enable
- denseb_addr  out  8  dense bias RAM address
- wt_data  out  8  byte for conv, dense and denseb RAMs (writedata[7:0])
- compute_start  out  1  one-cycle start pulse to compute engine
- compute_done  in  1  one-cycle done pulse from compute engine

Behaviour:
- Reset:
  - all outputs 0; state IDLE; count 0; error 0; checksum 0.
- Strobes:
  - wr = chipselect & write
  - rd = chipselect & read
- States: IDLE, LD_IMG, LD_CONV, LD_DENSE, LD_DENSEB, RUN, DONE.
- CTRL write (address 0):
  - bit1 = abort: from any state, go to IDLE, count cleared, no further wrens. Abort wins over bit0 in the same write.
  - bit0 = start: from IDLE or DONE, go to LD_IMG with count = 0 and error cleared. Ignored in any other state.
- DATA write (address 1) in a LD_* state:
  - Next cycle, the relevant wren is high for exactly one cycle.
  - The address output equals the pre-increment count, so the first write goes to address 0.
  - Data outputs are registered copies of writedata.
  - Then count increments.
- Phase end: on the write that makes count reach the phase total, the state advances and count resets to 0. Transitions: LD_IMG→LD_CONV→LD_DENSE→LD_DENSEB→RUN.
- RUN: compute_start pulses high for 1 cycle on entry. compute_done moves the state to DONE. compute_done in any other state is ignored.
- Errors: a DATA write in IDLE, RUN or DONE sets sticky error and produces no wren. A write to address 2 or 3 is ignored.
- Reads (1-cycle latency):
  - addr0 = {24'b0, error, done(state==DONE), busy(state!=IDLE&&state!=DONE), 2'b0, phase[2:0]}, with phase encoding IDLE=0 … DONE=6
  - addr1 = {16'b0, count}
  - addr2 = checksum (0 if feature absent)
  - readdata holds its last value when not reading.
- Only one wren is ever high in a given cycle.
- Reset mid-load returns to IDLE immediately. RAM contents are not cleared.

Optional Feature:
- NN_LOAD_CHECKSUM_EN defined:
  - 32-bit running sum of all accepted payload bytes (all 4 image bytes, plus wt_data bytes), wrapping modulo 2^32.
  - Cleared on start, readable at address 2.
- Undefined: no checksum logic; address 2 reads 0.

Test Plan:
- Reset, then read addr0 → 0x00000000; all wrens 0.
- Start, then 196 image writes of 0x01020304, each separated by 2 idle cycles → exactly 196 img_wren pulses with img_addr 0..195, img_data 0x01020304; status phase 1→2 after the 196th write; idle cycles cause no count change.
- Full load with small parameters (IMG 2, CONV 3, DENSE 3, DENSEB 2) → address sequences 0..N-1 per RAM, compute_start one pulse after the last bias write, phase=5; drive compute_done → phase=6, done=1.
- DATA write while IDLE → no wren, error=1; then start → error=0.
- Abort after 5 conv writes → phase 0, count 0; restart → image address resets to 0.
- With NN_LOAD_CHECKSUM_EN, small parameters, image words 0x01010101 ×2 and weight bytes all 0x02 (8 of them) → checksum = 24 (0x18).
